lc3_writeback: RTL
==================

// Module: lc3_writeback
// PURPOSE
//  Writeback stage of the LC-3 pipeline; sits downstream of the execute stage and memory access.
//  Selects the result (ALU, memory or PC) per W_Control, writes it into the 8-entry register file
//  and updates the PSR condition codes (NZP).
//  Provides the two register read ports consumed by decode/execute (VSR1/VSR2 for sr1/sr2).
// PARAMETERS
//  DATA_W     16  register/datapath width
//  NUM_REGS   8   register file depth (dr/sr index width = $clog2(NUM_REGS) = 3)
//  BYPASS     1   1: same-cycle write forwarded to read ports; 0: read returns pre-write value
// PORTS
//  clock            in   1   stage clock, all state on rising edge
//  reset            in   1   asynchronous, active-low reset
//  enable_writeback in   1   qualifies this cycle's write; 0 = hold all state
//  W_Control_out    in   2   result select: 00 aluout, 01 memout, 10 pcout, 11 illegal
//  aluout           in   16  ALU result from execute
//  pcout            in   16  PC-relative result from execute
//  memout           in   16  load data from memory access
//  dr               in   3   destination register index
//  sr1              in   3   read port 1 index
//  sr2              in   3   read port 2 index
//  VSR1             out  16  register[sr1] (combinational read)
//  VSR2             out  16  register[sr2] (combinational read)
//  psr              out  3   condition codes {N,Z,P}
//  wb_illegal       out  1   registered 1-cycle pulse: enabled write with W_Control_out==11
// BEHAVIOUR
//  Reset (reset==0, async): all registers R0..R7 = 16'h0000; psr = 3'b010; wb_illegal = 0.
//  - Reset is honoured mid-write; it overrides any concurrent write.
//  - First write is accepted on the first rising edge after reset deasserts.
//  Write:
//  - On rising edge with enable_writeback==1 and W_Control_out!=11: R[dr] <= selected value.
//  - Write latency 1 cycle: the value is visible on VSRx the cycle after the edge (BYPASS=0).
//  Condition codes, updated in the same edge from the selected value:
//  - bit15==1 -> psr=100
//  - value==0 -> psr=010
//  - otherwise -> psr=001
//  Illegal select (W_Control_out==11 with enable_writeback==1):
//  - no register write, psr unchanged
//  - wb_illegal=1 for exactly the next cycle
//  enable_writeback==0: no write, psr and wb_illegal hold/clear.
//  - wb_illegal clears to 0 on the next edge.
//  Reads: VSR1=R[sr1], VSR2=R[sr2], purely combinational, no enable gating.
//  Bypass (BYPASS=1):
//  - if a legal enabled write targets dr==sr1, VSR1 returns the write value in the same cycle.
//  - same rule for dr==sr2 / VSR2; both ports may bypass simultaneously (sr1==sr2==dr).
//  All registers are general purpose; R0 is writable (no hardwired zero).
//  Back-to-back writes to the same dr on consecutive cycles: last write wins, psr tracks each.
//  No X propagation: unused/illegal select never drives X onto register contents.
// TESTING
//  1. Reset check: assert reset=0 mid-run -> VSR1/VSR2=0 for all sr, psr=010, wb_illegal=0.
//  2. ALU write: en=1, W=00, aluout=16'h8001, dr=3 -> R3=8001, psr=100; next cycle sr1=3 gives VSR1=8001.
//  3. Mem/PC select with psr:
//     - W=01, memout=0, dr=5 -> R5=0, psr=010
//     - then W=10, pcout=16'h3005, dr=7 -> R7=3005, psr=001
//  4. Bypass (BYPASS=1): en=1, W=00, aluout=16'h1234, dr=sr1=sr2=2
//     -> VSR1=VSR2=1234 same cycle; BYPASS=0 -> old R2 value.
//  5. Illegal/enable:
//     - W=11, en=1, dr=4 -> R4 unchanged, psr unchanged, wb_illegal=1 for one cycle
//     - en=0 with W=00 -> no write
//  6. Async reset during write: reset=0 asserted between edges while en=1
//     -> register and psr reset immediately; the pending write is lost.

Source files
------------

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: picks the result (ALU, memory or PC), writes it into
// the register file, updates the NZP condition codes, and serves the two
// combinational register read ports used by decode/execute.
module lc3_writeback #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter bit BYPASS   = 1'b1,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control_out,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [IDX_W-1:0]  dr,
  input  logic [IDX_W-1:0]  sr1,
  input  logic [IDX_W-1:0]  sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr,
  output logic              wb_illegal
);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;
  localparam logic [1:0] SEL_ILL = 2'b11;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [2:0]        psr_q, psr_d;
  logic              ill_q, ill_d;

  logic signed [DATA_W-1:0] wdata;
  logic                     wr_legal;
  logic                     wr_illegal;

  // NZP from the sign and zero-ness of the value being written
  function automatic logic [2:0] cond_codes(input logic signed [DATA_W-1:0] v);
    if (v < 0)
      return CC_N;
    else if (v == '0)
      return CC_Z;
    else
      return CC_P;
  endfunction

  // Result mux; the illegal code selects zero so nothing undefined can leak.
  always_comb begin
    wdata = '0;
    case (W_Control_out)
      SEL_ALU: wdata = aluout;
      SEL_MEM: wdata = memout;
      SEL_PC:  wdata = pcout;
      default: wdata = '0;
    endcase
  end

  // A write is only real while reset is released, so an asserted reset also
  // suppresses the bypass path and the read ports show the cleared file.
  assign wr_legal   = reset && enable_writeback && (W_Control_out != SEL_ILL);
  assign wr_illegal = enable_writeback && (W_Control_out == SEL_ILL);

  // Next-state for the register file, condition codes and illegal pulse
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    psr_d = psr_q;
    ill_d = wr_illegal;
    if (wr_legal) begin
      regs_d[dr] = wdata;
      psr_d      = cond_codes(wdata);
    end
  end

  // State update; reset clears everything and wins over any concurrent write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      psr_q <= CC_Z;
      ill_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      psr_q <= psr_d;
      ill_q <= ill_d;
    end
  end

  // Read port 1, optionally forwarding a same-cycle write to the same index
  always_comb begin
    VSR1 = regs_q[sr1];
    if (BYPASS && wr_legal && (dr == sr1)) VSR1 = wdata;
  end

  // Read port 2, same forwarding rule as port 1
  always_comb begin
    VSR2 = regs_q[sr2];
    if (BYPASS && wr_legal && (dr == sr2)) VSR2 = wdata;
  end

  assign psr        = psr_q;
  assign wb_illegal = ill_q;

endmodule
